// File: rtl/dm_byte_store_pkg.sv
// Shared definitions for the data-memory byte store stage.
//   - Access-size encodings used by both store (st_type) and load (ld_type).
//   - Default array depth.
//   - sz_legal(): alignment/legality rule shared by the store and load paths.
package dm_byte_store_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam int DEPTH_WORDS_DEF = 1024;

    // Word needs a 4-byte aligned address, half needs an even address,
    // byte is always fine, the reserved encoding never is.
    function automatic logic sz_legal(input logic [1:0] addr_lo, input logic [1:0] size);
        logic ok;
        case (size)
            SZ_WORD: ok = (addr_lo == 2'b00);
            SZ_HALF: ok = (addr_lo[0] == 1'b0);
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_byte_store_be_gen.sv
// Byte-enable / lane-data generator for the store path (purely combinational).
// Ports:
//   i_addr_lo   [1:0]  low byte-address bits
//   i_size      [1:0]  access size (SZ_WORD/SZ_HALF/SZ_BYTE/SZ_RSVD)
//   i_wdata     [31:0] raw store data (half/byte taken from low bits)
//   o_byte_en   [3:0]  per-lane write enables (zero when illegal)
//   o_legal            access is aligned and of a defined size
//   o_lane_data [31:0] store data replicated across lanes
module dm_byte_store_be_gen
    import dm_byte_store_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_byte_en,
    output logic        o_legal,
    output logic [31:0] o_lane_data
);

    always_comb begin
        o_byte_en   = 4'b0000;
        o_lane_data = i_wdata;
        o_legal     = sz_legal(i_addr_lo, i_size);
        case (i_size)
            SZ_WORD: begin
                o_byte_en   = 4'b1111;
                o_lane_data = i_wdata;
            end
            SZ_HALF: begin
                o_byte_en   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_lane_data = {2{i_wdata[15:0]}};
            end
            SZ_BYTE: begin
                o_byte_en   = 4'b0001 << i_addr_lo;
                o_lane_data = {4{i_wdata[7:0]}};
            end
            default: begin
                o_byte_en   = 4'b0000;
                o_lane_data = i_wdata;
            end
        endcase
        // An illegal access must never touch the array.
        if (!o_legal) begin
            o_byte_en = 4'b0000;
        end
    end

endmodule

// File: rtl/dm_byte_store.sv
// Data memory stage feeding the load half/byte extractor.
// Stores (sw/sh/sb) write only the enabled byte lanes; loads return the full
// aligned word one cycle later together with the registered low address
// bits and load type. Misaligned/reserved accesses raise a one-cycle
// misalign pulse; illegal stores are dropped, illegal loads still return data.
// Ports:
//   clk, reset (async, active-low)
//   we, re          store / load request
//   st_type,ld_type access size
//   addr [31:0]     byte address (upper bits ignored, wraps)
//   wdata[31:0]     store data
//   rdata[31:0]     registered word read
//   rd_valid        rdata/addr_lo_q/ld_type_q valid pulse
//   addr_lo_q[1:0]  addr[1:0] captured with the read
//   ld_type_q[1:0]  ld_type captured with the read
//   misalign        registered illegal-access pulse
module dm_byte_store
    import dm_byte_store_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int IDX_W       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  st_type,
    input  logic [1:0]  ld_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rd_valid,
    output logic [1:0]  addr_lo_q,
    output logic [1:0]  ld_type_q,
    output logic        misalign
);

    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [31:0]      r_rdata;
    logic             r_rd_valid;
    logic [1:0]       r_addr_lo;
    logic [1:0]       r_ld_type;
    logic             r_misalign;

    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_byte_en;
    logic             w_st_legal;
    logic             w_ld_legal;
    logic [31:0]      w_lane_data;
    logic             w_unused_addr_hi;

    assign w_idx            = addr[IDX_W+1:2];
    // Upper address bits intentionally alias (address wraps modulo array size).
    assign w_unused_addr_hi = ^addr[31:IDX_W+2];
    assign w_ld_legal       = sz_legal(addr[1:0], ld_type);

    dm_byte_store_be_gen u_be_gen (
        .i_addr_lo   (addr[1:0]),
        .i_size      (st_type),
        .i_wdata     (wdata),
        .o_byte_en   (w_byte_en),
        .o_legal     (w_st_legal),
        .o_lane_data (w_lane_data)
    );

    // Read samples the pre-write word, giving read-before-write on a
    // same-cycle store/load to one address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_addr_lo  <= '0;
            r_ld_type  <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_byte_en[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
                    end
                end
            end
            if (re) begin
                r_rdata   <= r_mem[w_idx];
                r_addr_lo <= addr[1:0];
                r_ld_type <= ld_type;
            end
            r_rd_valid <= re;
            r_misalign <= (we & ~w_st_legal) | (re & ~w_ld_legal);
        end
    end

    assign rdata     = r_rdata;
    assign rd_valid  = r_rd_valid;
    assign addr_lo_q = r_addr_lo;
    assign ld_type_q = r_ld_type;
    assign misalign  = r_misalign;

endmodule

// File: tb/tb_dm_byte_store.sv
module tb_dm_byte_store;

    localparam logic [1:0] W = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] B = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  st_type = 2'b00;
    logic [1:0]  ld_type = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rd_valid;
    logic [1:0]  addr_lo_q;
    logic [1:0]  ld_type_q;
    logic        misalign;

    int n_vec  = 0;
    int n_miss = 0;

    dm_byte_store dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .re        (re),
        .st_type   (st_type),
        .ld_type   (ld_type),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rd_valid  (rd_valid),
        .addr_lo_q (addr_lo_q),
        .ld_type_q (ld_type_q),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        we = 1'b1; re = 1'b0; addr = a; wdata = d; st_type = t;
        tick();
        we = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] t);
        re = 1'b1; we = 1'b0; addr = a; ld_type = t;
        tick();
        re = 1'b0;
    endtask

    task automatic idle();
        we = 1'b0; re = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);
        chk("rst_addr_lo_q", {30'b0, addr_lo_q}, 32'h0);
        chk("rst_ld_type_q", {30'b0, ld_type_q}, 32'h0);
        #5 reset = 1'b1;
        tick();

        // First load after reset
        load(32'h10, W);
        chk("ld0_rdata", rdata, 32'h0);
        chk("ld0_valid", {31'b0, rd_valid}, 32'h1);
        chk("ld0_misalign", {31'b0, misalign}, 32'h0);
        idle();
        chk("idle_valid", {31'b0, rd_valid}, 32'h0);

        // Word then byte merge
        store(32'h20, 32'h12345678, W);
        chk("sw_misalign", {31'b0, misalign}, 32'h0);
        store(32'h21, 32'h000000AB, B);
        load(32'h23, B);
        chk("merge_rdata", rdata, 32'h1234AB78);
        chk("merge_addr_lo", {30'b0, addr_lo_q}, 32'h3);
        chk("merge_ld_type", {30'b0, ld_type_q}, 32'h2);
        chk("merge_misalign", {31'b0, misalign}, 32'h0);

        // Upper half store over zeroed word
        store(32'h42, 32'h0000BEEF, H);
        load(32'h40, W);
        chk("sh_hi_rdata", rdata, 32'hBEEF0000);

        // Illegal stores
        store(32'h30, 32'hCAFEF00D, W);
        store(32'h31, 32'hDEAD0000, W);
        chk("sw_mis_flag", {31'b0, misalign}, 32'h1);
        idle();
        chk("sw_mis_pulse_end", {31'b0, misalign}, 32'h0);
        store(32'h33, 32'h00001111, H);
        chk("sh_mis_flag", {31'b0, misalign}, 32'h1);
        store(32'h30, 32'h22222222, R);
        chk("rsvd_flag", {31'b0, misalign}, 32'h1);
        load(32'h30, W);
        chk("mis_unchanged", rdata, 32'hCAFEF00D);
        chk("mis_ld_ok", {31'b0, misalign}, 32'h0);

        // Misaligned load still returns the word
        load(32'h31, W);
        chk("misld_rdata", rdata, 32'hCAFEF00D);
        chk("misld_valid", {31'b0, rd_valid}, 32'h1);
        chk("misld_flag", {31'b0, misalign}, 32'h1);
        load(32'h32, H);
        chk("ldh_ok_flag", {31'b0, misalign}, 32'h0);

        // Read-before-write on the same word
        store(32'h50, 32'h11111111, W);
        we = 1'b1; re = 1'b1; addr = 32'h50; wdata = 32'hFFFFFFFF; st_type = W; ld_type = W;
        tick();
        we = 1'b0; re = 1'b0;
        chk("rbw_old", rdata, 32'h11111111);
        load(32'h50, W);
        chk("rbw_new", rdata, 32'hFFFFFFFF);

        // Back-to-back loads
        load(32'h20, W);
        chk("b2b0_rdata", rdata, 32'h1234AB78);
        load(32'h40, W);
        chk("b2b1_rdata", rdata, 32'hBEEF0000);
        chk("b2b1_valid", {31'b0, rd_valid}, 32'h1);

        // Byte at lane 2 replication/placement
        store(32'h62, 32'h000000C3, B);
        load(32'h60, W);
        chk("sb_lane2", rdata, 32'h00C30000);

        // Address wrap
        store(32'h1000, 32'hA5A55A5A, W);
        load(32'h0, W);
        chk("wrap_rdata", rdata, 32'hA5A55A5A);

        // Asynchronous reset mid-stream, with a store in flight
        we = 1'b1; addr = 32'h70; wdata = 32'h77777777; st_type = W;
        #2 reset = 1'b0;
        #1;
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_valid", {31'b0, rd_valid}, 32'h0);
        #10;
        we = 1'b0;
        reset = 1'b1;
        tick();
        load(32'h0, W);
        chk("arst_mem0", rdata, 32'h0);
        load(32'h20, W);
        chk("arst_mem20", rdata, 32'h0);
        load(32'h70, W);
        chk("arst_mem70", rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
